// File: rtl/xip_qspi_pkg.sv
// Shared constants and types for the XIP SPI/QSPI read engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package xip_qspi_pkg;

    // Flash opcodes: FAST READ (1-1-1) and QUAD OUTPUT READ (1-1-4)
    localparam logic [7:0] OPC_FAST_READ = 8'h0B;
    localparam logic [7:0] OPC_QUAD_READ = 8'h6B;

    // Pad state while idle: io2/io3 (nWP/nRESET) driven high, io0 driven low, io1 input
    localparam logic [3:0] PAD_IO_RST     = 4'b1100;
    localparam logic [3:0] PAD_OE_RST     = 4'b1101;
    // Quad dummy/data: every pad released so the flash can drive all four lines
    localparam logic [3:0] PAD_OE_QUAD_IN = 4'b0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/xip_sck_gen.sv
// Mode-0 serial clock generator: each sck phase lasts CLK_DIV clk_i cycles.
// Latency: rise/fall strobes are combinational and mark the clk edge at which sck toggles.
// Backpressure: none; dropping en_i forces sck low and restarts the divider.
module xip_sck_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             phase_end;

    assign phase_end = en_i && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise_o    = phase_end && !sck_o;
    assign fall_o    = phase_end && sck_o;

    // Divider counter and sck toggle; idle low whenever disabled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt <= '0;
            sck_o   <= 1'b0;
        end else if (!en_i) begin
            div_cnt <= '0;
            sck_o   <= 1'b0;
        end else if (phase_end) begin
            div_cnt <= '0;
            sck_o   <= !sck_o;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/xip_qspi_reader.sv
// Read-only SPI/QSPI flash engine for execute-in-place: opcode, address, dummy, data burst.
// Latency: accept->rsp_valid = 1 + 2*CLK_DIV*(8+ADDR_W+DUMMY_CYCLES+NDATA) clk cycles.
// Backpressure: req_ready_o low from accept until the csn idle gap has elapsed.
module xip_qspi_reader
    import xip_qspi_pkg::*;
#(
    parameter int ADDR_W       = 24,
    parameter int DATA_BYTES   = 4,
    parameter int CLK_DIV      = 1,
    parameter int DUMMY_CYCLES = 8,
    parameter int CS_IDLE      = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_W-1:0]       req_addr_i,
    input  logic                    req_quad_i,
    output logic                    rsp_valid_o,
    output logic [8*DATA_BYTES-1:0] rsp_data_o,
    output logic                    spi_csn_o,
    output logic                    spi_sck_o,
    output logic [3:0]              spi_io_o,
    output logic [3:0]              spi_io_oe_o,
    input  logic [3:0]              spi_io_i
);

    localparam int TX_W     = 8 + ADDR_W;
    localparam int RX_W     = 8 * DATA_BYTES;
    localparam int CNT_MAX  = max_int(max_int(ADDR_W, RX_W), max_int(DUMMY_CYCLES, 8));
    localparam int CNT_W    = $clog2(CNT_MAX);
    // The GAP state always lasts at least one cycle, so csn stays high for max(CS_IDLE, 2)
    localparam int GAP_LOAD = (CS_IDLE > 2) ? CS_IDLE - 2 : 0;
    localparam int GAP_W    = $clog2(GAP_LOAD + 2);

    localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_ADDR  = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] CNT_DUMMY = CNT_W'(DUMMY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_DS    = CNT_W'(RX_W - 1);
    localparam logic [CNT_W-1:0] CNT_DQ    = CNT_W'(2 * DATA_BYTES - 1);

    state_t            state;
    logic              quad;
    logic [TX_W-1:0]   tx_sr;
    logic [RX_W-1:0]   rx_sr;
    logic [RX_W-1:0]   rx_swapped;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  data_load;
    logic [GAP_W-1:0]  gap_cnt;
    logic              data_done;
    logic              sck_en;
    logic              sck_rise;
    logic              sck_fall;
    logic [7:0]        accept_opc;

    assign req_ready_o = (state == ST_IDLE);
    assign accept_opc  = req_quad_i ? OPC_QUAD_READ : OPC_FAST_READ;
    assign data_load   = quad ? CNT_DQ : CNT_DS;
    // sck stops after the last data falling edge so the completion cycle sees sck low
    assign sck_en      = !data_done && (state == ST_CMD || state == ST_ADDR ||
                                        state == ST_DUMMY || state == ST_DATA);

    xip_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (sck_en),
        .sck_o  (spi_sck_o),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    // First flash byte arrives first, so it sits in the top byte of rx_sr; move it to [7:0]
    always_comb begin
        rx_swapped = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            rx_swapped[8*k +: 8] = rx_sr[RX_W-8-8*k +: 8];
        end
    end

    // Transfer sequencer: phase counting, shift registers, csn and pad drive
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            quad        <= 1'b0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            data_done   <= 1'b0;
            spi_csn_o   <= 1'b1;
            spi_io_o    <= PAD_IO_RST;
            spi_io_oe_o <= PAD_OE_RST;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        // First opcode bit is set up together with the csn fall
                        quad        <= req_quad_i;
                        tx_sr       <= {accept_opc, req_addr_i};
                        spi_csn_o   <= 1'b0;
                        spi_io_o    <= {PAD_IO_RST[3:1], accept_opc[7]};
                        spi_io_oe_o <= PAD_OE_RST;
                        bit_cnt     <= CNT_CMD;
                        state       <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (sck_fall) begin
                        tx_sr       <= tx_sr << 1;
                        spi_io_o[0] <= tx_sr[TX_W-2];
                        if (bit_cnt == '0) begin
                            bit_cnt <= CNT_ADDR;
                            state   <= ST_ADDR;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_fall) begin
                        if (bit_cnt == '0) begin
                            // Turnaround: quad releases every pad, single parks io0 low
                            if (quad) begin
                                spi_io_oe_o <= PAD_OE_QUAD_IN;
                            end else begin
                                spi_io_o    <= PAD_IO_RST;
                            end
                            if (DUMMY_CYCLES == 0) begin
                                bit_cnt <= data_load;
                                state   <= ST_DATA;
                            end else begin
                                bit_cnt <= CNT_DUMMY;
                                state   <= ST_DUMMY;
                            end
                        end else begin
                            tx_sr       <= tx_sr << 1;
                            spi_io_o[0] <= tx_sr[TX_W-2];
                            bit_cnt     <= bit_cnt - 1'b1;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (sck_fall) begin
                        if (bit_cnt == '0) begin
                            bit_cnt <= data_load;
                            state   <= ST_DATA;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (data_done) begin
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= rx_swapped;
                        spi_csn_o   <= 1'b1;
                        spi_io_o    <= PAD_IO_RST;
                        spi_io_oe_o <= PAD_OE_RST;
                        data_done   <= 1'b0;
                        gap_cnt     <= GAP_W'(GAP_LOAD);
                        state       <= ST_GAP;
                    end else begin
                        if (sck_rise) begin
                            if (quad) begin
                                rx_sr <= {rx_sr[RX_W-5:0], spi_io_i};
                            end else begin
                                rx_sr <= {rx_sr[RX_W-2:0], spi_io_i[1]};
                            end
                        end
                        if (sck_fall) begin
                            if (bit_cnt == '0) begin
                                data_done <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt - 1'b1;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xip_qspi_reader.sv
// Bench for xip_qspi_reader: unit 0 runs CLK_DIV=1, unit 1 runs CLK_DIV=3, each with a flash model.
// Latency: responses are timed against the accept edge.
// Backpressure: requests wait for req_ready before being counted as accepted.
module tb_xip_qspi_reader;

    localparam int NU = 2;

    typedef struct {
        logic [31:0] data;
        int          lat;
        logic [31:0] cmd;
        logic        quad;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [NU];
    logic        req_ready [NU];
    logic [23:0] req_addr  [NU];
    logic        req_quad  [NU];
    logic        rsp_valid [NU];
    logic [31:0] rsp_data  [NU];
    logic        csn       [NU];
    logic        sck       [NU];
    logic [3:0]  io_o      [NU];
    logic [3:0]  io_oe     [NU];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            default:    return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    for (genvar g = 0; g < NU; g++) begin : g_unit
        int          rc  = 0;
        logic [31:0] cap = '0;
        logic [3:0]  fo  = '0;

        xip_qspi_reader #(
            .ADDR_W       (24),
            .DATA_BYTES   (4),
            .CLK_DIV      ((g == 0) ? 1 : 3),
            .DUMMY_CYCLES (8),
            .CS_IDLE      (2)
        ) dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .req_valid_i (req_valid[g]),
            .req_ready_o (req_ready[g]),
            .req_addr_i  (req_addr[g]),
            .req_quad_i  (req_quad[g]),
            .rsp_valid_o (rsp_valid[g]),
            .rsp_data_o  (rsp_data[g]),
            .spi_csn_o   (csn[g]),
            .spi_sck_o   (sck[g]),
            .spi_io_o    (io_o[g]),
            .spi_io_oe_o (io_oe[g]),
            .spi_io_i    (fo)
        );

        // Flash: count rising edges per select, capture opcode+address from io0
        always @(posedge sck[g] or posedge csn[g]) begin
            if (csn[g]) begin
                rc = 0;
            end else begin
                rc++;
                if (rc <= 32) cap = {cap[30:0], io_o[g][0]};
            end
        end

        // Flash: launch data on falling sck once the 8 dummy clocks are done
        always @(negedge sck[g]) begin
            int          j;
            logic [7:0]  b;
            if (!csn[g] && rc >= 40) begin
                j = rc - 40;
                if (cap[31:24] == 8'h6B) begin
                    if (j < 8) begin
                        b  = fbyte(cap[23:0] + 24'(j / 2));
                        fo = (j % 2 == 0) ? b[7:4] : b[3:0];
                    end
                end else if (j < 32) begin
                    b     = fbyte(cap[23:0] + 24'(j / 8));
                    fo    = 4'b0000;
                    fo[1] = b[7 - (j % 8)];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request; when push is set, the expected response goes to the scoreboard
    task automatic issue(input int k, input logic [23:0] a, input logic q, input logic [31:0] d,
                         input int lat, input bit push, input bit keep);
        exp_t e;
        int   n;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_addr[k]  = a;
        req_quad[k]  = q;
        n = 0;
        while (!req_ready[k] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[k]) begin
            chk("accept_timeout", 64'(req_ready[k]), 64'd1);
            req_valid[k] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (push) begin
            e.data = d;
            e.lat  = lat;
            e.cmd  = {(q ? 8'h6B : 8'h0B), a};
            e.quad = q;
            e.acc  = cyc;
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        if (!keep) req_valid[k] = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0)
            chk("drain_timeout", 64'(q0.size() + q1.size()), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    // Monitor: scoreboard pops on rsp_valid, plus csn gap, ready and pad-drive watching
    int   hi_run   [NU] = '{0, 0};
    logic prev_csn [NU] = '{1'b1, 1'b1};
    int   viol     [NU] = '{0, 0};

    always @(negedge clk) begin
        exp_t        e;
        bit          have;
        logic        qf;
        int          rcv;
        logic [31:0] capv;
        for (int k = 0; k < NU; k++) begin
            rcv  = (k == 0) ? g_unit[0].rc  : g_unit[1].rc;
            capv = (k == 0) ? g_unit[0].cap : g_unit[1].cap;
            have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
            qf   = 1'b0;
            if (have) qf = (k == 0) ? q0[0].quad : q1[0].quad;
            if (csn[k]) begin
                hi_run[k]++;
            end else begin
                if (prev_csn[k]) chk("csn_gap_ok", 64'(hi_run[k] >= 2), 64'd1);
                hi_run[k] = 0;
                if (req_ready[k]) viol[k]++;
                if (have && rcv < 32 && (io_oe[k] != 4'b1101 || io_o[k][3:2] != 2'b11)) viol[k]++;
                if (have && rcv >= 33) begin
                    if (qf && io_oe[k] != 4'b0000) viol[k]++;
                    if (!qf && (io_oe[k] != 4'b1101 || io_o[k] != 4'b1100)) viol[k]++;
                end
            end
            prev_csn[k] = csn[k];
            if (rsp_valid[k]) begin
                if (!have) begin
                    chk("unexpected_rsp", 64'(rsp_valid[k]), 64'd0);
                end else begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    chk("rsp_data", 64'(rsp_data[k]), 64'(e.data));
                    chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    chk("cmd_addr", 64'(capv), 64'(e.cmd));
                    chk("pad_ready_viol", 64'(viol[k]), 64'd0);
                    viol[k] = 0;
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < NU; k++) begin
            req_valid[k] = 1'b0;
            req_addr[k]  = '0;
            req_quad[k]  = 1'b0;
        end
        // Values while reset is held
        repeat (3) @(negedge clk);
        for (int k = 0; k < NU; k++)
            chk("in_reset", {csn[k], sck[k], io_o[k], io_oe[k], req_ready[k], rsp_valid[k]},
                {1'b1, 1'b0, 4'b1100, 4'b1101, 1'b1, 1'b0});
        rst = 1'b0;
        // Idle after reset, no request
        repeat (4) begin
            @(negedge clk);
            for (int k = 0; k < NU; k++)
                chk("idle", {csn[k], sck[k], io_o[k], io_oe[k], req_ready[k], rsp_valid[k]},
                    {1'b1, 1'b0, 4'b1100, 4'b1101, 1'b1, 1'b0});
        end
        chk("idle_rsp_data", 64'(rsp_data[0]), 64'd0);

        // Single and quad reads of 11 22 33 44
        issue(0, 24'h000100, 1'b0, 32'h44332211, 145, 1'b1, 1'b0);
        wait_drain();
        issue(0, 24'h000100, 1'b1, 32'h44332211, 97, 1'b1, 1'b0);
        wait_drain();

        // Reset in the middle of the address phase
        issue(0, 24'h000100, 1'b0, 32'h0, 0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_csn", {csn[0], sck[0], req_ready[0]}, {1'b1, 1'b0, 1'b1});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(0, 24'hABCDE0, 1'b0, 32'h46474445, 145, 1'b1, 1'b0);
        wait_drain();

        // Back-to-back with valid held high
        issue(0, 24'h000102, 1'b1, 32'hA0A14433, 97, 1'b1, 1'b1);
        issue(0, 24'h000100, 1'b0, 32'h44332211, 145, 1'b1, 1'b0);
        wait_drain();

        // Divided clock, top of the address space
        issue(1, 24'hFFFFFC, 1'b1, 32'h5A5B5859, 289, 1'b1, 1'b0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule
